// File: rtl/ca_row_sequencer_if.sv
// ca_row_sequencer_if: one-row-per-cycle frame buffer write port
//   wr_en   write strobe, one cycle per row
//   wr_row  row address
//   wr_data row contents, bit WIDTH-1 = leftmost cell
interface ca_row_sequencer_if #(
  parameter int WIDTH = 80,
  parameter int ROW_W = 7
);
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [WIDTH-1:0] wr_data;
  modport master (output wr_en, wr_row, wr_data);
  modport slave  (input  wr_en, wr_row, wr_data);
endinterface

// File: rtl/ca_row_sequencer.sv
// ca_row_sequencer: 1-D cellular automaton generation engine feeding a row frame buffer
//   clk, rstn          clock, async active-low reset
//   step, restart      next-generation request, clear-and-reseed request
//   rule_load, rule_in rule register load
//   wr                 frame buffer write port (master)
//   top_row            oldest row on screen (scroll offset)
//   busy, step_drop    not idle, ignored step pulse
//   gen_count, rule    generations since seed (saturating), current rule
module ca_row_sequencer #(
  parameter int               WIDTH = 80,
  parameter int               ROWS  = 60,
  parameter int               ROW_W = 7,
  parameter logic [WIDTH-1:0] SEED  = {1'b1, {(WIDTH-1){1'b0}}},
  parameter logic [7:0]       RULE0 = 8'd30
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  step,
  input  logic                  restart,
  input  logic                  rule_load,
  input  logic [7:0]            rule_in,
  ca_row_sequencer_if.master    wr,
  output logic [ROW_W-1:0]      top_row,
  output logic                  busy,
  output logic                  step_drop,
  output logic [15:0]           gen_count,
  output logic [7:0]            rule
);
  typedef enum logic [2:0] {CLEAR, SEEDW, IDLE, CALC, WRITE} state_e;
  state_e           state_q, state_d;
  logic [ROW_W-1:0] clr_ptr_q, clr_ptr_d, next_row_q, next_row_d, wr_row_q, wr_row_d;
  logic [WIDTH-1:0] cur_q, cur_d, wr_data_q, wr_data_d, nxt;
  logic [7:0]       rule_q, rule_d;
  logic [15:0]      gen_q, gen_d;
  logic             full_q, full_d, wr_en_q, wr_en_d, wrap;
  always_comb begin
    nxt = '0;
    for (int i = 0; i < WIDTH; i++)
      nxt[i] = rule_q[{cur_q[(i+1)%WIDTH], cur_q[i], cur_q[(i+WIDTH-1)%WIDTH]}];
  end
  assign wrap = next_row_q == ROW_W'(ROWS-1);
  // The write port is registered with look-ahead: it is loaded on the edge that
  // enters a writing state, so the strobe is visible for the whole of that state.
  // Right after reset CLEAR has not issued row 0 yet; wr_en_q=0 marks that case.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    cur_d      = cur_q;
    next_row_d = next_row_q;
    full_d     = full_q;
    gen_d      = gen_q;
    rule_d     = rule_load ? rule_in : rule_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_data_d  = wr_data_q;
    if (restart) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
      wr_en_d   = 1'b1;
      wr_row_d  = '0;
      wr_data_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          wr_en_d = 1'b1;
          if (wr_en_q && clr_ptr_q == ROW_W'(ROWS-1)) begin
            state_d   = SEEDW;
            wr_row_d  = '0;
            wr_data_d = SEED;
          end else begin
            clr_ptr_d = wr_en_q ? clr_ptr_q + ROW_W'(1) : clr_ptr_q;
            wr_row_d  = clr_ptr_d;
            wr_data_d = '0;
          end
        end
        SEEDW: begin
          state_d    = IDLE;
          cur_d      = SEED;
          next_row_d = ROW_W'(1);
          full_d     = 1'b0;
          gen_d      = '0;
        end
        IDLE: state_d = step ? CALC : IDLE;
        CALC: begin
          state_d   = WRITE;
          cur_d     = nxt;
          wr_en_d   = 1'b1;
          wr_row_d  = next_row_q;
          wr_data_d = nxt;
        end
        WRITE: begin
          state_d    = IDLE;
          next_row_d = wrap ? '0 : next_row_q + ROW_W'(1);
          full_d     = full_q | wrap;
          gen_d      = gen_q + 16'(gen_q != 16'hFFFF);
        end
        default: begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      cur_q      <= SEED;
      next_row_q <= '0;
      full_q     <= 1'b0;
      gen_q      <= '0;
      rule_q     <= RULE0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      cur_q      <= cur_d;
      next_row_q <= next_row_d;
      full_q     <= full_d;
      gen_q      <= gen_d;
      rule_q     <= rule_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_data_q  <= wr_data_d;
    end
  end
  assign wr.wr_en   = wr_en_q;
  assign wr.wr_row  = wr_row_q;
  assign wr.wr_data = wr_data_q;
  assign busy       = state_q != IDLE;
  assign step_drop  = step & busy;
  assign top_row    = full_q ? next_row_q : '0;
  assign gen_count  = gen_q;
  assign rule       = rule_q;
endmodule

// File: tb/tb_ca_row_sequencer.sv
// tb_ca_row_sequencer: directed and randomized checks of ca_row_sequencer against a behavioural model
module tb_ca_row_sequencer;
  localparam int          R    = 60;
  localparam logic [79:0] SEED = {1'b1, 79'b0};
  logic        clk = 1'b0, rstn = 1'b0, step = 1'b0, restart = 1'b0, rule_load = 1'b0;
  logic [7:0]  rule_in = 8'd0, rule;
  logic [6:0]  top_row;
  logic        busy, step_drop;
  logic [15:0] gen_count;
  int          vectors = 0, miscompares = 0;
  logic [6:0]  log_row[$];
  logic [79:0] log_data[$];
  logic [79:0] m_cur;
  logic [7:0]  m_rule = 8'd30;
  int          m_next_row, m_gen;
  bit          m_full;
  ca_row_sequencer_if #(.WIDTH(80), .ROW_W(7)) wr();
  ca_row_sequencer dut (
    .clk(clk), .rstn(rstn), .step(step), .restart(restart),
    .rule_load(rule_load), .rule_in(rule_in), .wr(wr),
    .top_row(top_row), .busy(busy), .step_drop(step_drop),
    .gen_count(gen_count), .rule(rule)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (wr.wr_en === 1'b1) begin
      log_row.push_back(wr.wr_row);
      log_data.push_back(wr.wr_data);
    end
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Each cell looks at (left,self,right) = (bit i+1, bit i, bit i-1) with wrap;
  // built bit-parallel from rotated copies, one minterm per set rule bit.
  function automatic logic [79:0] ca_step(input logic [79:0] c, input logic [7:0] r);
    logic [79:0] l = {c[0], c[79:1]};
    logic [79:0] rr = {c[78:0], c[79]};
    logic [79:0] n = '0;
    for (int k = 0; k < 8; k++)
      if (r[k]) n |= (k[2] ? l : ~l) & (k[1] ? c : ~c) & (k[0] ? rr : ~rr);
    return n;
  endfunction
  task automatic model_seed();
    m_cur = SEED; m_next_row = 1; m_full = 0; m_gen = 0;
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_gen"}, 80'(gen_count), 80'(m_gen));
    chk({tag, "_top_row"}, 80'(top_row), 80'(m_full ? m_next_row : 0));
    chk({tag, "_rule"}, 80'(rule), 80'(m_rule));
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 80'(busy), 80'(1'b0));
  endtask
  task automatic check_clear(input string tag);
    chk({tag, "_writes"}, 80'(log_row.size()), 80'(61));
    for (int i = 0; i < 61 && i < log_row.size(); i++) begin
      chk($sformatf("%s_row%0d", tag, i), 80'(log_row[i]), 80'(i == 60 ? 0 : i));
      chk($sformatf("%s_data%0d", tag, i), log_data[i], i == 60 ? SEED : 80'(0));
    end
  endtask
  task automatic expect_write(input string tag);
    m_cur = ca_step(m_cur, m_rule);
    chk({tag, "_wr_en"}, 80'(wr.wr_en), 80'(1'b1));
    chk({tag, "_wr_row"}, 80'(wr.wr_row), 80'(m_next_row));
    chk({tag, "_wr_data"}, wr.wr_data, m_cur);
    m_next_row = (m_next_row + 1) % R;
    if (m_next_row == 0) m_full = 1;
    if (m_gen < 65535) m_gen++;
  endtask
  task automatic do_step(input logic [7:0] r, input bit ld);
    rule_in = r; rule_load = ld; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0; rule_load = 1'b0;
    if (ld) m_rule = r;
    @(negedge clk);
    chk("calc_wr_en", 80'(wr.wr_en), 80'(1'b0));
    chk("calc_busy", 80'(busy), 80'(1'b1));
    @(negedge clk);
    expect_write("step");
    @(negedge clk);
    chk("step_busy", 80'(busy), 80'(1'b0));
    check_state("step");
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 80'(busy), 80'(1'b1));
    chk("rst_wr_en", 80'(wr.wr_en), 80'(1'b0));
    chk("rst_wr_row", 80'(wr.wr_row), 80'(0));
    chk("rst_wr_data", wr.wr_data, 80'(0));
    chk("rst_step_drop", 80'(step_drop), 80'(1'b0));
    chk("rst_top_row", 80'(top_row), 80'(0));
    chk("rst_gen", 80'(gen_count), 80'(0));
    chk("rst_rule", 80'(rule), 80'(30));
    @(posedge clk); #1;
    rstn = 1'b1;
    log_row.delete(); log_data.delete();
    wait_idle();
    @(posedge clk); #1;
    check_clear("init");
    model_seed();
    check_state("init");
    do_step(8'd0, 1'b0);
    chk("rule30_first_gen", wr.wr_data, 80'hC000_0000_0000_0000_0001);
    do_step(8'd0, 1'b1);
    chk("rule0_zeros", wr.wr_data, 80'(0));
    do_step(8'd255, 1'b1);
    chk("rule255_ones", wr.wr_data, {80{1'b1}});
    for (int n = 0; n < 66; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_step(8'($urandom), $urandom_range(0, 1) == 1);
    end
    chk("wrapped_full", 80'(m_full), 80'(1'b1));
    repeat (2) @(negedge clk);
    #1;
    log_row.delete(); log_data.delete();
    step = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("dbl_step_drop", 80'(step_drop), 80'(1'b1));
    @(posedge clk); #1;
    step = 1'b0;
    @(negedge clk);
    expect_write("dbl");
    @(negedge clk);
    check_state("dbl");
    repeat (3) @(negedge clk);
    #1;
    chk("dbl_writes", 80'(log_row.size()), 80'(1));
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0; restart = 1'b1;
    @(negedge clk);
    chk("rs_calc_busy", 80'(busy), 80'(1'b1));
    @(posedge clk); #1;
    restart = 1'b0;
    log_row.delete(); log_data.delete();
    @(negedge clk);
    chk("rs_no_write_row", 80'(wr.wr_row), 80'(0));
    chk("rs_no_write_data", wr.wr_data, 80'(0));
    step = 1'b1;
    #1;
    chk("clear_step_drop", 80'(step_drop), 80'(1'b1));
    @(posedge clk); #1;
    step = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    log_row.delete(); log_data.delete();
    @(negedge clk);
    chk("rs_clear_row0", 80'(wr.wr_row), 80'(0));
    wait_idle();
    @(posedge clk); #1;
    check_clear("restart");
    model_seed();
    check_state("restart");
    for (int n = 0; n < 4; n++) do_step(8'($urandom), n != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
